// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: per-loop start/end addresses and iteration counters
// with commit-gated decrement, in-flight decrement flags and a synchronous kill.
module riscv_hwloop_regs #(
  parameter int HWLP_NUM = 4,
  parameter int REGID_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    hwlp_we_i,
  input  logic [REGID_W-1:0]            hwlp_regid_i,
  input  logic [31:0]                   hwlp_start_data_i,
  input  logic [31:0]                   hwlp_end_data_i,
  input  logic [31:0]                   hwlp_cnt_data_i,
  input  logic [HWLP_NUM-1:0]           hwlp_cnt_dec_i,
  input  logic                          id_valid_i,
  input  logic                          clear_i,
  output logic [HWLP_NUM-1:0][31:0]     hwlp_start_addr_o,
  output logic [HWLP_NUM-1:0][31:0]     hwlp_end_addr_o,
  output logic [HWLP_NUM-1:0][31:0]     hwlp_counter_o,
  output logic [HWLP_NUM-1:0]           hwlp_cnt_dec_id_o,
  output logic [HWLP_NUM-1:0]           hwlp_active_o
);

  logic [HWLP_NUM-1:0][31:0] r_start;
  logic [HWLP_NUM-1:0][31:0] r_end;
  logic [HWLP_NUM-1:0][31:0] r_cnt;
  logic [HWLP_NUM-1:0]       r_dec_id;
  logic [HWLP_NUM-1:0]       w_sel;
  logic [HWLP_NUM-1:0]       w_commit;

  genvar gi;
  generate
    for (gi = 0; gi < HWLP_NUM; gi++) begin : g_loop
      // An index beyond HWLP_NUM matches no slot, so such writes fall away.
      assign w_sel[gi]    = (hwlp_regid_i == REGID_W'(gi));
      assign w_commit[gi] = hwlp_cnt_dec_i[gi] && id_valid_i && (r_cnt[gi] != 32'd0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_start[gi]  <= 32'd0;
          r_end[gi]    <= 32'd0;
          r_cnt[gi]    <= 32'd0;
          r_dec_id[gi] <= 1'b0;
        end else begin
          if (hwlp_we_i[0] && w_sel[gi])
            r_start[gi] <= {hwlp_start_data_i[31:2], 2'b00};
          if (hwlp_we_i[1] && w_sel[gi])
            r_end[gi] <= {hwlp_end_data_i[31:2], 2'b00};

          // Priority: kill, then explicit counter write, then committed decrement.
          if (clear_i) begin
            r_cnt[gi]    <= 32'd0;
            r_dec_id[gi] <= 1'b0;
          end else if (hwlp_we_i[2] && w_sel[gi]) begin
            r_cnt[gi]    <= hwlp_cnt_data_i;
            r_dec_id[gi] <= 1'b0;
          end else if (w_commit[gi]) begin
            r_cnt[gi]    <= r_cnt[gi] - 32'd1;
            r_dec_id[gi] <= 1'b1;
          end else begin
            r_dec_id[gi] <= 1'b0;
          end
        end
      end

      assign hwlp_active_o[gi] = (r_cnt[gi] != 32'd0);
    end
  endgenerate

  assign hwlp_start_addr_o = r_start;
  assign hwlp_end_addr_o   = r_end;
  assign hwlp_counter_o    = r_cnt;
  assign hwlp_cnt_dec_id_o = r_dec_id;

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Self-checking bench for riscv_hwloop_regs: directed scenarios plus randomized
// traffic compared against a per-loop behavioural model.
module tb_riscv_hwloop_regs;

  logic             clk;
  logic             rst_n;
  logic [2:0]       we;
  logic [1:0]       regid;
  logic [31:0]      sd, ed, cd;
  logic [3:0]       dec;
  logic             idv, clr;
  logic [3:0][31:0] so, eo, co;
  logic [3:0]       dio, act;
  logic [2:0][31:0] so3, eo3, co3;
  logic [2:0]       dio3, act3;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned m_start [4];
  int unsigned m_end   [4];
  int unsigned m_cnt   [4];
  bit          m_decid [4];

  riscv_hwloop_regs #(.HWLP_NUM(4), .REGID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .hwlp_we_i(we), .hwlp_regid_i(regid),
    .hwlp_start_data_i(sd), .hwlp_end_data_i(ed), .hwlp_cnt_data_i(cd),
    .hwlp_cnt_dec_i(dec), .id_valid_i(idv), .clear_i(clr),
    .hwlp_start_addr_o(so), .hwlp_end_addr_o(eo), .hwlp_counter_o(co),
    .hwlp_cnt_dec_id_o(dio), .hwlp_active_o(act)
  );

  riscv_hwloop_regs #(.HWLP_NUM(3), .REGID_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .hwlp_we_i(we), .hwlp_regid_i(regid),
    .hwlp_start_data_i(sd), .hwlp_end_data_i(ed), .hwlp_cnt_data_i(cd),
    .hwlp_cnt_dec_i(dec[2:0]), .id_valid_i(idv), .clear_i(clr),
    .hwlp_start_addr_o(so3), .hwlp_end_addr_o(eo3), .hwlp_counter_o(co3),
    .hwlp_cnt_dec_id_o(dio3), .hwlp_active_o(act3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_start[i] = 0; m_end[i] = 0; m_cnt[i] = 0; m_decid[i] = 0;
    end
  endtask

  // Next state of every loop from the current inputs, per the register-file rules.
  task automatic model_update();
    for (int i = 0; i < 4; i++) begin
      bit hit;
      bit done;
      hit  = (int'(regid) == i);
      done = dec[i] && idv && (m_cnt[i] > 0);
      if (we[0] && hit) m_start[i] = sd & 32'hFFFF_FFFC;
      if (we[1] && hit) m_end[i]   = ed & 32'hFFFF_FFFC;
      m_decid[i] = 0;
      if (clr)                m_cnt[i] = 0;
      else if (we[2] && hit)  m_cnt[i] = cd;
      else if (done) begin
        m_cnt[i]   = m_cnt[i] - 1;
        m_decid[i] = 1;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 3'b000; regid = 2'd0; sd = 0; ed = 0; cd = 0; dec = 4'b0; idv = 0; clr = 0;
  endtask

  task automatic write_cnt(input int id, input int unsigned val);
    idle(); we = 3'b100; regid = 2'(id); cd = val; tick(); idle();
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (so[i] !== 32'd0 || eo[i] !== 32'd0 || co[i] !== 32'd0) begin
        n_err++;
        $display("FAIL reset_regs loop%0d: got start=%h end=%h cnt=%h, want all 0", i, so[i], eo[i], co[i]);
      end
    end
    n_cmp++;
    if (dio !== 4'b0 || act !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got dec_id=%b active=%b, want 0000/0000", dio, act);
    end
  endtask

  task automatic test_setup();
    idle();
    we = 3'b111; regid = 2'd1; sd = 32'h100; ed = 32'h123; cd = 32'd5;
    tick(); idle();
    n_cmp++;
    if (so[1] !== 32'h100 || eo[1] !== 32'h120 || co[1] !== 32'd5) begin
      n_err++;
      $display("FAIL setup_loop1: got start=%h end=%h cnt=%0d, want 100/120/5", so[1], eo[1], co[1]);
    end
    n_cmp++;
    if (act !== 4'b0010) begin
      n_err++;
      $display("FAIL setup_active: got %b, want 0010", act);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      n_cmp++;
      if (so[i] !== 32'd0 || eo[i] !== 32'd0 || co[i] !== 32'd0) begin
        n_err++;
        $display("FAIL setup_other loop%0d: got start=%h end=%h cnt=%h, want 0", i, so[i], eo[i], co[i]);
      end
    end
  endtask

  task automatic test_decrement();
    int unsigned exp_cnt [5] = '{2, 1, 0, 0, 0};
    bit          exp_pul [5] = '{1, 1, 1, 0, 0};
    write_cnt(0, 3);
    for (int k = 0; k < 5; k++) begin
      dec = 4'b0001; idv = 1'b1;
      tick();
      n_cmp++;
      if (co[0] !== exp_cnt[k] || dio[0] !== exp_pul[k] || act[0] !== (exp_cnt[k] != 0)) begin
        n_err++;
        $display("FAIL dec_seq step%0d: got cnt=%0d dec_id=%b active=%b, want %0d/%b/%b",
                 k, co[0], dio[0], act[0], exp_cnt[k], exp_pul[k], exp_cnt[k] != 0);
      end
    end
    write_cnt(0, 3);
    for (int k = 0; k < 2; k++) begin
      dec = 4'b0001; idv = 1'b0;
      tick();
      n_cmp++;
      if (co[0] !== 32'd3 || dio[0] !== 1'b0) begin
        n_err++;
        $display("FAIL dec_stall step%0d: got cnt=%0d dec_id=%b, want 3/0", k, co[0], dio[0]);
      end
    end
    idle();
  endtask

  task automatic test_collision();
    write_cnt(2, 7);
    we = 3'b100; regid = 2'd2; cd = 32'd10; dec = 4'b0100; idv = 1'b1;
    tick(); idle();
    n_cmp++;
    if (co[2] !== 32'd10 || dio[2] !== 1'b0) begin
      n_err++;
      $display("FAIL collide_same: got cnt2=%0d dec_id2=%b, want 10/0", co[2], dio[2]);
    end
    write_cnt(2, 7);
    we = 3'b100; regid = 2'd3; cd = 32'd10; dec = 4'b0100; idv = 1'b1;
    tick(); idle();
    n_cmp++;
    if (co[2] !== 32'd6 || co[3] !== 32'd10 || dio[2] !== 1'b1) begin
      n_err++;
      $display("FAIL collide_diff: got cnt2=%0d cnt3=%0d dec_id2=%b, want 6/10/1", co[2], co[3], dio[2]);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) write_cnt(i, i + 1);
    clr = 1'b1; we = 3'b100; regid = 2'd0; cd = 32'd9; dec = 4'b1111; idv = 1'b1;
    tick(); idle();
    n_cmp++;
    if (co !== '0 || dio !== 4'b0 || act !== 4'b0) begin
      n_err++;
      $display("FAIL clear_cnt: got cnt=%h dec_id=%b active=%b, want 0", co, dio, act);
    end
    n_cmp++;
    if (so[1] !== 32'h100 || eo[1] !== 32'h120) begin
      n_err++;
      $display("FAIL clear_keep_addr: got start1=%h end1=%h, want 100/120", so[1], eo[1]);
    end
  endtask

  task automatic test_async_reset();
    write_cnt(1, 9);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (so !== '0 || eo !== '0 || co !== '0 || dio !== 4'b0 || act !== 4'b0) begin
      n_err++;
      $display("FAIL async_reset: got cnt1=%0d start1=%h dec_id=%b active=%b, want all 0", co[1], so[1], dio, act);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dec = 4'b1111; idv = 1'b1;
      tick();
      n_cmp++;
      if (co !== '0 || dio !== 4'b0) begin
        n_err++;
        $display("FAIL post_reset_dec step%0d: got cnt=%h dec_id=%b, want 0", k, co, dio);
      end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      we = 3'b111; regid = 2'(i);
      sd = 32'h1000 + 32'(i) * 32'h10; ed = 32'h2000 + 32'(i) * 32'h10; cd = 32'(i + 1);
      tick();
    end
    we = 3'b111; regid = 2'd3; sd = 32'hDEAD_BEEF; ed = 32'hCAFE_F00D; cd = 32'd77;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (so3[i] !== 32'h1000 + 32'(i) * 32'h10 || eo3[i] !== 32'h2000 + 32'(i) * 32'h10 ||
          co3[i] !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL oob_ignore loop%0d: got start=%h end=%h cnt=%0d, want %h/%h/%0d", i, so3[i], eo3[i],
                 co3[i], 32'h1000 + 32'(i) * 32'h10, 32'h2000 + 32'(i) * 32'h10, i + 1);
      end
    end
    n_cmp++;
    if (co[3] !== 32'd77 || so[3] !== 32'hDEAD_BEEC || eo[3] !== 32'hCAFE_F00C) begin
      n_err++;
      $display("FAIL full_loop3: got start=%h end=%h cnt=%0d, want deadbeec/cafef00c/77", so[3], eo[3], co[3]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      we    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      regid = 2'($urandom);
      sd    = $urandom; ed = $urandom;
      cd    = $urandom_range(0, 4);
      dec   = 4'($urandom);
      idv   = 1'($urandom);
      clr   = ($urandom_range(0, 29) == 0);
      tick();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (so[i] !== m_start[i] || eo[i] !== m_end[i] || co[i] !== m_cnt[i] ||
            dio[i] !== m_decid[i] || act[i] !== (m_cnt[i] != 0)) begin
          n_err++;
          $display("FAIL random cyc%0d loop%0d: got s=%h e=%h c=%0d d=%b a=%b, want s=%h e=%h c=%0d d=%b a=%b",
                   k, i, so[i], eo[i], co[i], dio[i], act[i],
                   m_start[i], m_end[i], m_cnt[i], m_decid[i], m_cnt[i] != 0);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_setup();
    test_decrement();
    test_collision();
    test_clear();
    test_async_reset();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
